// File: rtl/seq_acc_pkg.sv
// Shared definitions for the seq_acc32 stream accumulator: state encoding,
// datapath width and the state decode helper.
package seq_acc_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    // The unused encoding 2'd3 behaves exactly like IDLE.
    function automatic state_e decode_state(input logic [1:0] raw);
        state_e dec;
        case (raw)
            2'd0:    dec = IDLE;
            2'd1:    dec = ACCUM;
            2'd2:    dec = DONE;
            default: dec = IDLE;
        endcase
        return dec;
    endfunction

endpackage

// File: rtl/acc_add32.sv
// Purely combinational 32-bit adder with carry-in and carry-out, used as the
// accumulation datapath of seq_acc32.
module acc_add32
    import seq_acc_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
    output logic [DATA_W-1:0] sum,
    output logic              cout
);

    logic [DATA_W:0] full_s;

    // 33-bit add so the carry-out falls out of the top bit.
    always_comb begin
        full_s = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cin};
    end

    assign sum  = full_s[DATA_W-1:0];
    assign cout = full_s[DATA_W];

endmodule

// File: rtl/seq_acc32.sv
// Stream accumulator: takes a command with an operand count, sums that many
// operands modulo 2^32, counts carry-outs and offers the result on a
// valid/ready port. Optional sticky signed overflow: SEQ_ACC32_SIGNED_OVF_EN.
module seq_acc32
    import seq_acc_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sum,
    output logic [LEN_W-1:0]  out_carry_cnt,
    output logic              out_ovf,
    output logic              busy
);

    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] LEN_MAX  = {LEN_W{1'b1}};

    logic [1:0]        state_r;
    state_e            state_dec_s;
    state_e            state_nxt_s;
    logic [DATA_W-1:0] acc_r;
    logic [DATA_W-1:0] acc_nxt_s;
    logic [LEN_W-1:0]  carry_cnt_r;
    logic [LEN_W-1:0]  carry_cnt_nxt_s;
    logic [LEN_W-1:0]  remaining_r;
    logic [LEN_W-1:0]  remaining_nxt_s;
    logic [DATA_W-1:0] add_sum_s;
    logic              add_cout_s;
    logic              xfer_s;
    logic              clr_s;

    acc_add32 u_add (
        .a    (acc_r),
        .b    (in_data),
        .cin  (1'b0),
        .sum  (add_sum_s),
        .cout (add_cout_s)
    );

    assign state_dec_s = decode_state(state_r);

    // Next-state and datapath update logic; every register holds by default.
    always_comb begin
        state_nxt_s     = state_dec_s;
        acc_nxt_s       = acc_r;
        carry_cnt_nxt_s = carry_cnt_r;
        remaining_nxt_s = remaining_r;
        xfer_s          = 1'b0;
        clr_s           = 1'b0;
        case (state_dec_s)
            IDLE: begin
                if (start) begin
                    clr_s           = 1'b1;
                    acc_nxt_s       = {DATA_W{1'b0}};
                    carry_cnt_nxt_s = LEN_ZERO;
                    remaining_nxt_s = len;
                    if (len != LEN_ZERO) begin
                        state_nxt_s = ACCUM;
                    end else begin
                        state_nxt_s = DONE;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    xfer_s          = 1'b1;
                    acc_nxt_s       = add_sum_s;
                    remaining_nxt_s = remaining_r - LEN_ONE;
                    if (add_cout_s && (carry_cnt_r != LEN_MAX)) begin
                        carry_cnt_nxt_s = carry_cnt_r + LEN_ONE;
                    end else begin
                        carry_cnt_nxt_s = carry_cnt_r;
                    end
                    if (remaining_r == LEN_ONE) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = ACCUM;
                    end
                end else begin
                    state_nxt_s = ACCUM;
                end
            end
            DONE: begin
                // A start arriving with the handshake is deliberately dropped.
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, accumulator and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            acc_r       <= {DATA_W{1'b0}};
            carry_cnt_r <= LEN_ZERO;
            remaining_r <= LEN_ZERO;
        end else begin
            state_r     <= state_nxt_s;
            acc_r       <= acc_nxt_s;
            carry_cnt_r <= carry_cnt_nxt_s;
            remaining_r <= remaining_nxt_s;
        end
    end

`ifdef SEQ_ACC32_SIGNED_OVF_EN
    logic ovf_r;
    logic ovf_nxt_s;

    // Sticky signed overflow: same-sign operands giving a result of the other sign.
    always_comb begin
        ovf_nxt_s = ovf_r;
        if (clr_s) begin
            ovf_nxt_s = 1'b0;
        end else if (xfer_s) begin
            ovf_nxt_s = ovf_r | ((acc_r[DATA_W-1] == in_data[DATA_W-1]) &&
                                 (add_sum_s[DATA_W-1] != acc_r[DATA_W-1]));
        end else begin
            ovf_nxt_s = ovf_r;
        end
    end

    // Overflow flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_nxt_s;
        end
    end

    assign out_ovf = ovf_r && (state_dec_s == DONE);
`else
    assign out_ovf = 1'b0;
`endif

    // Outputs are straight decodes of registered state, so they stay stable
    // for as long as DONE is held.
    assign in_ready      = (state_dec_s == ACCUM);
    assign out_valid     = (state_dec_s == DONE);
    assign busy          = (state_dec_s != IDLE);
    assign out_sum       = acc_r;
    assign out_carry_cnt = carry_cnt_r;

endmodule
